mem_bus_peripheral: RTL and testbench

- Memory-mapped peripheral responder on the CPU data bus; the device end of the MemBus_Address / MemBus_Write_Data / MemRead / MemWrite / Device_Read_Data interface.
- Provides a reloadable timer with interrupt, a free-running system tick counter, an LED register and a 7-segment digit register.
- Sits beside data memory; the top-level bus mux selects Device_Read_Data when the address falls in this block's window.

---
 rtl/mem_bus_peripheral.sv | 128 ++++++++++++
 tb/tb_mem_bus_peripheral.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_peripheral.sv
// mem_bus_peripheral
//   Device end of the CPU data bus. Decodes a 32-byte window at BASE_ADDR and
//   exposes six word registers:
//     offset 0  TH       timer reload value
//     offset 1  TL       timer count (counts up, reloads from TH after 32'hFFFF_FFFF)
//     offset 2  TCON     {irq_status, irq_enable, enable}
//     offset 3  LED      LED output register
//     offset 4  DIGI     {anode[3:0], segments[7:0]} output register
//     offset 5  SYSTICK  free-running cycle counter, read-only
//   Offsets 6 and 7 read as zero and ignore writes.
//
// Ports
//   clk                in   system clock, rising edge
//   reset              in   synchronous active-high reset
//   MemBus_Address     in   byte address; bits [1:0] ignored
//   MemBus_Write_Data  in   write data
//   MemRead            in   read strobe
//   MemWrite           in   write strobe, sampled at the rising edge
//   Device_Read_Data   out  combinational read data, zero when not selected
//   irq                out  timer interrupt request (TCON[2]), level
//   leds               out  LED register
//   digits             out  digit register
module mem_bus_peripheral #(
  parameter logic [31:0] BASE_ADDR  = 32'h4000_0000,
  parameter int          LED_WIDTH  = 8,
  parameter int          DIGI_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           MemBus_Address,
  input  logic [31:0]           MemBus_Write_Data,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  output logic [31:0]           Device_Read_Data,
  output logic                  irq,
  output logic [LED_WIDTH-1:0]  leds,
  output logic [DIGI_WIDTH-1:0] digits
);

  localparam logic [2:0] OFS_TH      = 3'd0;
  localparam logic [2:0] OFS_TL      = 3'd1;
  localparam logic [2:0] OFS_TCON    = 3'd2;
  localparam logic [2:0] OFS_LED     = 3'd3;
  localparam logic [2:0] OFS_DIGI    = 3'd4;
  localparam logic [2:0] OFS_SYSTICK = 3'd5;

  localparam logic [31:0] TL_MAX = 32'hFFFF_FFFF;

  logic [31:0]           thReg;
  logic [31:0]           tlReg;
  logic [2:0]            tconReg;
  logic [LED_WIDTH-1:0]  ledReg;
  logic [DIGI_WIDTH-1:0] digiReg;
  logic [31:0]           sysTick;

  logic       hit;
  logic [2:0] offset;
  logic       wrEn;
  logic       timerOverflow;

  // Byte-lane bits carry no meaning for word registers.
  logic unusedByteLane;
  assign unusedByteLane = ^MemBus_Address[1:0];

  assign hit           = (MemBus_Address[31:5] == BASE_ADDR[31:5]);
  assign offset        = MemBus_Address[4:2];
  assign wrEn          = MemWrite && hit;
  assign timerOverflow = tconReg[0] && (tlReg == TL_MAX);

  // CPU writes are applied after the timer update in the same block so a
  // write to TL or TCON wins over the increment/reload and status set. The
  // reload reads thReg before this edge, so a concurrent TH write only
  // affects the next reload.
  always_ff @(posedge clk) begin
    if (reset) begin
      thReg   <= '0;
      tlReg   <= '0;
      tconReg <= '0;
      ledReg  <= '0;
      digiReg <= '0;
      sysTick <= '0;
    end else begin
      sysTick <= sysTick + 32'd1;

      if (tconReg[0]) begin
        if (timerOverflow) begin
          tlReg <= thReg;
          if (tconReg[1]) begin
            tconReg[2] <= 1'b1;
          end
        end else begin
          tlReg <= tlReg + 32'd1;
        end
      end

      if (wrEn) begin
        case (offset)
          OFS_TH:   thReg   <= MemBus_Write_Data;
          OFS_TL:   tlReg   <= MemBus_Write_Data;
          OFS_TCON: tconReg <= MemBus_Write_Data[2:0];
          OFS_LED:  ledReg  <= MemBus_Write_Data[LED_WIDTH-1:0];
          OFS_DIGI: digiReg <= MemBus_Write_Data[DIGI_WIDTH-1:0];
          default:  ;
        endcase
      end
    end
  end

  always_comb begin
    Device_Read_Data = '0;
    if (MemRead && hit) begin
      case (offset)
        OFS_TH:      Device_Read_Data = thReg;
        OFS_TL:      Device_Read_Data = tlReg;
        OFS_TCON:    Device_Read_Data[2:0] = tconReg;
        OFS_LED:     Device_Read_Data[LED_WIDTH-1:0] = ledReg;
        OFS_DIGI:    Device_Read_Data[DIGI_WIDTH-1:0] = digiReg;
        OFS_SYSTICK: Device_Read_Data = sysTick;
        default:     Device_Read_Data = '0;
      endcase
    end
  end

  assign irq    = tconReg[2];
  assign leds   = ledReg;
  assign digits = digiReg;

endmodule

// File: tb/tb_mem_bus_peripheral.sv
module tb_mem_bus_peripheral;

  logic        clk;
  logic        reset;
  logic [31:0] MemBus_Address;
  logic [31:0] MemBus_Write_Data;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Device_Read_Data;
  logic        irq;
  logic [7:0]  leds;
  logic [11:0] digits;

  mem_bus_peripheral #(
    .BASE_ADDR (32'h4000_0000),
    .LED_WIDTH (8),
    .DIGI_WIDTH(12)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .MemBus_Address   (MemBus_Address),
    .MemBus_Write_Data(MemBus_Write_Data),
    .MemRead          (MemRead),
    .MemWrite         (MemWrite),
    .Device_Read_Data (Device_Read_Data),
    .irq              (irq),
    .leds             (leds),
    .digits           (digits)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [31:0] A_TH   = 32'h4000_0000;
  localparam logic [31:0] A_TL   = 32'h4000_0004;
  localparam logic [31:0] A_TCON = 32'h4000_0008;
  localparam logic [31:0] A_LED  = 32'h4000_000C;
  localparam logic [31:0] A_DIGI = 32'h4000_0010;
  localparam logic [31:0] A_TICK = 32'h4000_0014;

  typedef struct {
    logic        rst;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] expRd;
    logic        expIrq;
    logic [7:0]  expLeds;
    logic [11:0] expDigits;
    logic        tick;
  } vec_t;

  int nChecks = 0;
  int nFails  = 0;

  // Reference cycle counter for SYSTICK.
  logic [31:0] tickModel;
  always @(posedge clk) begin
    if (reset) tickModel <= 32'd0;
    else       tickModel <= tickModel + 32'd1;
  end

  function automatic vec_t mk(logic rst, logic rd, logic wr, logic [31:0] addr,
                              logic [31:0] wdata, logic [31:0] expRd, logic expIrq,
                              logic [7:0] expLeds, logic [11:0] expDigits, logic tick);
    vec_t v;
    v.rst = rst; v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata;
    v.expRd = expRd; v.expIrq = expIrq; v.expLeds = expLeds;
    v.expDigits = expDigits; v.tick = tick;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One bus cycle: drive, compare before the edge, then let the edge happen.
  task automatic run(input vec_t v, input string nm);
    logic [31:0] expRd;
    reset             = v.rst;
    MemRead           = v.rd;
    MemWrite          = v.wr;
    MemBus_Address    = v.addr;
    MemBus_Write_Data = v.wdata;
    @(negedge clk);
    expRd = v.tick ? tickModel : v.expRd;
    check({nm, ".rd"},     Device_Read_Data, expRd);
    check({nm, ".irq"},    {31'd0, irq},     {31'd0, v.expIrq});
    check({nm, ".leds"},   {24'd0, leds},    {24'd0, v.expLeds});
    check({nm, ".digits"}, {20'd0, digits},  {20'd0, v.expDigits});
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[$];

  initial begin
    reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0;
    MemBus_Address = '0; MemBus_Write_Data = '0;

    //          rst rd wr addr          wdata          expRd          irq leds   digits  tick
    tbl.push_back(mk(0, 1, 0, A_TH,        32'h0,         32'h0,         0, 8'h00, 12'h000, 0));
    tbl.push_back(mk(0, 1, 0, A_TL,        32'h0,         32'h0,         0, 8'h00, 12'h000, 0));
    tbl.push_back(mk(0, 1, 0, A_TCON,      32'h0,         32'h0,         0, 8'h00, 12'h000, 0));
    tbl.push_back(mk(0, 1, 0, A_LED,       32'h0,         32'h0,         0, 8'h00, 12'h000, 0));
    tbl.push_back(mk(0, 1, 0, A_DIGI,      32'h0,         32'h0,         0, 8'h00, 12'h000, 0));
    tbl.push_back(mk(0, 0, 1, A_LED,       32'h1234_56A5, 32'h0,         0, 8'h00, 12'h000, 0));
    tbl.push_back(mk(0, 0, 1, A_DIGI,      32'hFFFF_F7C0, 32'h0,         0, 8'hA5, 12'h000, 0));
    tbl.push_back(mk(0, 1, 0, A_LED,       32'h0,         32'h0000_00A5, 0, 8'hA5, 12'h7C0, 0));
    tbl.push_back(mk(0, 1, 0, A_DIGI,      32'h0,         32'h0000_07C0, 0, 8'hA5, 12'h7C0, 0));
    tbl.push_back(mk(0, 1, 1, A_LED,       32'h0000_005A, 32'h0000_00A5, 0, 8'hA5, 12'h7C0, 0));
    tbl.push_back(mk(0, 1, 0, A_LED,       32'h0,         32'h0000_005A, 0, 8'h5A, 12'h7C0, 0));
    tbl.push_back(mk(0, 1, 1, 32'h4000_0018, 32'hFFFF_FFFF, 32'h0,       0, 8'h5A, 12'h7C0, 0));
    tbl.push_back(mk(0, 1, 0, 32'h4000_001C, 32'h0,       32'h0,         0, 8'h5A, 12'h7C0, 0));
    tbl.push_back(mk(0, 1, 1, 32'h5000_000C, 32'h0,       32'h0,         0, 8'h5A, 12'h7C0, 0));
    tbl.push_back(mk(0, 1, 0, A_LED,       32'h0,         32'h0000_005A, 0, 8'h5A, 12'h7C0, 0));
    tbl.push_back(mk(0, 1, 1, 32'h4000_0003, 32'h1111_2222, 32'h0,       0, 8'h5A, 12'h7C0, 0));
    tbl.push_back(mk(0, 1, 0, 32'h4000_0001, 32'h0,       32'h1111_2222, 0, 8'h5A, 12'h7C0, 0));
    tbl.push_back(mk(0, 0, 0, A_LED,       32'h0,         32'h0,         0, 8'h5A, 12'h7C0, 0));
    tbl.push_back(mk(0, 1, 0, A_TCON,      32'h0,         32'h0,         0, 8'h5A, 12'h7C0, 0));
    tbl.push_back(mk(0, 1, 0, A_TL,        32'h0,         32'h0,         0, 8'h5A, 12'h7C0, 0));

    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // SYSTICK reads 0 right after reset, then counts once per cycle.
    for (int i = 0; i < 4; i++)
      run(mk(0, 1, 0, A_TICK, 0, 0, 0, 8'h00, 12'h000, 1), $sformatf("tick%0d", i));
    check("tick_abs", tickModel, 32'd4);

    for (int i = 0; i < tbl.size(); i++)
      run(tbl[i], $sformatf("tbl%0d", i));

    // Writes to SYSTICK are ignored.
    run(mk(0, 1, 1, A_TICK, 32'h0, 0, 0, 8'h5A, 12'h7C0, 1), "tickwr");
    run(mk(0, 1, 0, A_TICK, 32'h0, 0, 0, 8'h5A, 12'h7C0, 1), "tickafter");

    // Timer reload and periodic overflow.
    run(mk(0, 0, 1, A_TH,   32'hFFFF_FFFC, 32'h0, 0, 8'h5A, 12'h7C0, 0), "setTH");
    run(mk(0, 0, 1, A_TL,   32'hFFFF_FFFE, 32'h0, 0, 8'h5A, 12'h7C0, 0), "setTL");
    run(mk(0, 0, 1, A_TCON, 32'h0000_0003, 32'h0, 0, 8'h5A, 12'h7C0, 0), "setTCON");
    run(mk(0, 1, 0, A_TL,   32'h0, 32'hFFFF_FFFE, 0, 8'h5A, 12'h7C0, 0), "tA");
    run(mk(0, 1, 0, A_TL,   32'h0, 32'hFFFF_FFFF, 0, 8'h5A, 12'h7C0, 0), "tB");
    run(mk(0, 1, 0, A_TL,   32'h0, 32'hFFFF_FFFC, 1, 8'h5A, 12'h7C0, 0), "tC");
    run(mk(0, 1, 0, A_TCON, 32'h0, 32'h0000_0007, 1, 8'h5A, 12'h7C0, 0), "tD");
    run(mk(0, 1, 0, A_TL,   32'h0, 32'hFFFF_FFFE, 1, 8'h5A, 12'h7C0, 0), "tE");
    run(mk(0, 1, 0, A_TL,   32'h0, 32'hFFFF_FFFF, 1, 8'h5A, 12'h7C0, 0), "tF");
    run(mk(0, 1, 0, A_TL,   32'h0, 32'hFFFF_FFFC, 1, 8'h5A, 12'h7C0, 0), "tG");
    run(mk(0, 1, 0, A_TL,   32'h0, 32'hFFFF_FFFD, 1, 8'h5A, 12'h7C0, 0), "tH");
    run(mk(0, 1, 0, A_TL,   32'h0, 32'hFFFF_FFFE, 1, 8'h5A, 12'h7C0, 0), "tI");

    // Clear irq in the overflow cycle: CPU write wins over status set.
    run(mk(0, 1, 1, A_TCON, 32'h0000_0003, 32'h0000_0007, 1, 8'h5A, 12'h7C0, 0), "clrJ");
    run(mk(0, 1, 0, A_TCON, 32'h0, 32'h0000_0003, 0, 8'h5A, 12'h7C0, 0), "clrK");
    run(mk(0, 1, 0, A_TL,   32'h0, 32'hFFFF_FFFD, 0, 8'h5A, 12'h7C0, 0), "clrL");
    run(mk(0, 1, 0, A_TL,   32'h0, 32'hFFFF_FFFE, 0, 8'h5A, 12'h7C0, 0), "clrM");

    // TH write in the overflow cycle: reload uses old TH.
    run(mk(0, 1, 1, A_TH,   32'hFFFF_FFF0, 32'hFFFF_FFFC, 0, 8'h5A, 12'h7C0, 0), "thN");
    run(mk(0, 1, 0, A_TL,   32'h0, 32'hFFFF_FFFC, 1, 8'h5A, 12'h7C0, 0), "thO");
    run(mk(0, 1, 0, A_TH,   32'h0, 32'hFFFF_FFF0, 1, 8'h5A, 12'h7C0, 0), "thP");
    run(mk(0, 1, 0, A_TL,   32'h0, 32'hFFFF_FFFE, 1, 8'h5A, 12'h7C0, 0), "thQ");
    run(mk(0, 1, 0, A_TL,   32'h0, 32'hFFFF_FFFF, 1, 8'h5A, 12'h7C0, 0), "thR");
    run(mk(0, 1, 0, A_TL,   32'h0, 32'hFFFF_FFF0, 1, 8'h5A, 12'h7C0, 0), "thS");

    // TL write beats increment; disabling the timer holds TL.
    run(mk(0, 1, 1, A_TL,   32'h0000_0100, 32'hFFFF_FFF1, 1, 8'h5A, 12'h7C0, 0), "tlT");
    run(mk(0, 1, 0, A_TL,   32'h0, 32'h0000_0100, 1, 8'h5A, 12'h7C0, 0), "tlU");
    run(mk(0, 0, 1, A_TCON, 32'h0000_0000, 32'h0, 1, 8'h5A, 12'h7C0, 0), "offV");
    run(mk(0, 1, 0, A_TL,   32'h0, 32'h0000_0102, 0, 8'h5A, 12'h7C0, 0), "offW");
    run(mk(0, 1, 0, A_TL,   32'h0, 32'h0000_0102, 0, 8'h5A, 12'h7C0, 0), "offX");

    // Reset mid-count with TL at overflow and TCON=7.
    run(mk(0, 0, 1, A_TCON, 32'h0000_0007, 32'h0, 0, 8'h5A, 12'h7C0, 0), "rstY");
    run(mk(0, 1, 1, A_TL,   32'hFFFF_FFFF, 32'h0000_0102, 1, 8'h5A, 12'h7C0, 0), "rstZ");
    run(mk(1, 1, 0, A_TL,   32'h0, 32'hFFFF_FFFF, 1, 8'h5A, 12'h7C0, 0), "rstAA");
    run(mk(0, 1, 0, A_TL,   32'h0, 32'h0, 0, 8'h00, 12'h000, 0), "postTL");
    run(mk(0, 1, 0, A_TCON, 32'h0, 32'h0, 0, 8'h00, 12'h000, 0), "postTCON");
    run(mk(0, 1, 0, A_TH,   32'h0, 32'h0, 0, 8'h00, 12'h000, 0), "postTH");
    run(mk(0, 1, 0, A_LED,  32'h0, 32'h0, 0, 8'h00, 12'h000, 0), "postLED");
    run(mk(0, 1, 0, A_DIGI, 32'h0, 32'h0, 0, 8'h00, 12'h000, 0), "postDIGI");
    run(mk(0, 1, 0, A_TICK, 32'h0, 32'h0, 0, 8'h00, 12'h000, 1), "postTick");
    check("postTick_abs", tickModel, 32'd6);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
